linebuffer_window9: RTL and testbench
=====================================

// Module: linebuffer_window9
// PURPOSE
//  Streaming 9x9 window generator for the logistic-regression pipeline. Accepts one 7-bit pixel
//  per valid cycle, raster order. Keeps 8 image lines plus a 9x9 register window, and presents
//  81 window pixels on the unpacked xarray bus that feeds the inner-product units.
//  Flags each complete, non-wrapping window with a one-cycle win_valid.
// PARAMETERS
//  IMG_W   28  pixels per image line (>= 9)
//  IMG_H   28  lines per frame (>= 9)
//  PIX_W   7   pixel width (from lr_pkg)
//  WIN     9   window edge; NFEAT = WIN*WIN = 81
// PORTS
//  clk        in   1           single clock, all logic rising-edge
//  rst        in   1           asynchronous, active-high reset
//  in_valid   in   1           pixel strobe; gaps allowed, no backpressure
//  in_sof     in   1           start of frame, qualified by in_valid
//  in_data    in   PIX_W       pixel value
//  xarray     out  [6:0][0:80] window, k = r*9+c; r0 = oldest line, c0 = oldest column
//  win_valid  out  1           1-cycle pulse: xarray holds a new complete window
//  win_row    out  clog2(IMG_H) line of newest pixel (window bottom-right)
//  win_col    out  clog2(IMG_W) column of newest pixel (window bottom-right)
//  frame_done out  1           1-cycle pulse: last pixel of the frame accepted
// BEHAVIOUR
//  - Reset (async, any time): xarray = 0, win_valid = 0, frame_done = 0, win_row/col = 0,
//    row/col counters = 0, line-buffer pointers = 0. Line-buffer storage is not reset.
//  - Accept = in_valid. When in_valid = 0, all state holds. xarray is stable between accepts.
//  - Counters: col increments on each accept. At IMG_W-1, col -> 0 and row++. At (IMG_H-1,
//    IMG_W-1), both wrap to 0 (next frame, no in_sof needed) and frame_done pulses.
//  - in_sof with in_valid: the accepted pixel is taken as (0,0), whatever the counters held.
//    Mid-frame sof resynchronises, and no window is valid until row>=8 and col>=8 again.
//  - Line buffers: chain of 8 IMG_W-deep delays. lb0 input = in_data, lbN input = lb(N-1)
//    output. All advance only on accept.
//  - Window shift on accept: every row shifts one column toward c0. Column c8 is loaded with
//    r8 = in_data, r7 = lb0 out, ..., r0 = lb7 out.
//  - win_valid: registered with the shift. High the cycle after accepting pixel (row,col)
//    with row >= 8 and col >= 8. win_row/win_col latch that (row,col).
//  - Latency: 1 clk from accept to xarray/win_valid update. With continuous input, windows
//    per frame = (IMG_H-8)*(IMG_W-8) = 400 at defaults.
//  - Boundary cases:
//    - col < 8 suppresses win_valid, so windows never span a line wrap.
//    - Last pixel of a frame gives win_valid and frame_done in the same cycle.
//    - sof on the last pixel slot: sof wins, and frame_done is not raised.
//  - xarray[0] is driven like every other slot. Consumers may replace it with the bias term.
//  - Arithmetic: counters are unsigned. Pixels are passed through unmodified, no saturation.
// STRUCTURE
//  - lr_pkg: PIX_W=7, WIN=9, NFEAT=81, typedef logic [PIX_W-1:0] pix_t.
//  - Sub-module linebuf_row: one IMG_W-deep pixel delay with enable. It is a circular RAM
//    with one shared pointer and is instantiated 8 times.
//  - Top level contains the row/col counters, the 9x9 shift array, and valid/done flags.
// TESTING
//  1. Reset mid-stream (rst high for 1 cycle at any point) -> all outputs 0 next edge;
//     no win_valid until 233 pixels after the next accepted pixel.
//  2. Continuous frame, pixel = (r*28+c)%128, sof on (0,0):
//     - first win_valid after the 233rd accept, with xarray[0]=0, xarray[8]=8,
//       xarray[72]=224%128=96, xarray[80]=104, win_row=8, win_col=8;
//     - exactly 400 pulses; frame_done once, coincident with the pulse for (27,27).
//  3. Same frame with random in_valid gaps (about 40% idle) -> identical sequence of 400
//     xarray snapshots; xarray holds steady during gaps.
//  4. Second frame without sof -> counters wrap, and again 400 windows; the first window
//     contains only second-frame pixels.
//  5. sof asserted at pixel (12,5) of a frame -> no win_valid for the next 232 accepts;
//     the 233rd accept gives win_valid with win_row=8, win_col=8.
//  6. Column edge: for every line with row>=8, col 0..7 accepts -> win_valid=0;
//     col 27 -> win_valid=1 and the following col-0 accept -> 0.

Source files
------------

// File: rtl/lr_pkg.sv
// Shared types and constants for the logistic-regression pixel pipeline.
// Pixel width and window geometry are fixed here so every stage agrees on them.
package lr_pkg;

    localparam int PIX_W = 7;
    localparam int WIN   = 9;
    localparam int NFEAT = WIN * WIN;
    localparam int NLB   = WIN - 1;

    typedef logic [PIX_W-1:0] pix_t;

endpackage

// File: rtl/linebuf_row.sv
// One image line of pixel delay: a circular RAM read and written at the same pointer,
// so a pixel written on an enabled cycle reappears DEPTH enabled cycles later.
module linebuf_row
    import lr_pkg::*;
#(
    parameter  int DEPTH = 28,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             en,
    input  logic [PTR_W-1:0] ptr,
    input  pix_t             wr_data,
    output pix_t             rd_data
);

    pix_t mem_q [DEPTH];

    // Read returns the pixel stored one line ago, before this cycle's write lands.
    assign rd_data = mem_q[ptr];

    // NOTE: the RAM has no reset; every slot is rewritten before it reaches a valid window.
    always_ff @(posedge clk) begin
        if (en) begin
            mem_q[ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/linebuffer_window9.sv
// Streaming 9x9 window generator: eight line delays feed the right-hand column of a
// register window that shifts left on every accepted pixel.
module linebuffer_window9
    import lr_pkg::*;
#(
    parameter  int IMG_W = 28,
    parameter  int IMG_H = 28,
    localparam int COL_W = $clog2(IMG_W),
    localparam int ROW_W = $clog2(IMG_H)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    input  pix_t             in_data,
    output pix_t             xarray [0:NFEAT-1],
    output logic             win_valid,
    output logic [ROW_W-1:0] win_row,
    output logic [COL_W-1:0] win_col,
    output logic             frame_done
);

    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [COL_W-1:0] ptr_q, ptr_d;
    pix_t             win_q [0:NFEAT-1];
    pix_t             win_d [0:NFEAT-1];
    logic             win_valid_q, win_valid_d;
    logic [ROW_W-1:0] win_row_q, win_row_d;
    logic [COL_W-1:0] win_col_q, win_col_d;
    logic             frame_done_q, frame_done_d;

    pix_t             lb_in  [NLB];
    pix_t             lb_out [NLB];
    pix_t             col_in [WIN];

    logic [ROW_W-1:0] cur_row;
    logic [COL_W-1:0] cur_col;
    logic             last_row, last_col;

    assign lb_in[0] = in_data;

    for (genvar n = 0; n < NLB; n++) begin : g_lb
        if (n > 0) begin : g_chain
            assign lb_in[n] = lb_out[n-1];
        end
        linebuf_row #(.DEPTH(IMG_W)) u_row (
            .clk     (clk),
            .en      (in_valid),
            .ptr     (ptr_q),
            .wr_data (lb_in[n]),
            .rd_data (lb_out[n])
        );
    end

    // Window row r8 takes the live pixel; row r receives the output of line delay 7-r.
    always_comb begin
        for (int r = 0; r < WIN; r++) begin
            col_in[r] = (r == WIN - 1) ? in_data : lb_out[WIN-2-r];
        end
    end

    // A start-of-frame pixel is placed at (0,0) regardless of where the counters were.
    assign cur_row  = in_sof ? '0 : row_q;
    assign cur_col  = in_sof ? '0 : col_q;
    assign last_row = (cur_row == ROW_W'(IMG_H - 1));
    assign last_col = (cur_col == COL_W'(IMG_W - 1));

    // NOTE: every variable gets its hold value first so no path leaves one unassigned (no latch).
    always_comb begin
        row_d        = row_q;
        col_d        = col_q;
        ptr_d        = ptr_q;
        win_d        = win_q;
        win_valid_d  = 1'b0;
        win_row_d    = win_row_q;
        win_col_d    = win_col_q;
        frame_done_d = 1'b0;

        if (in_valid) begin
            ptr_d = (ptr_q == COL_W'(IMG_W - 1)) ? '0 : ptr_q + 1'b1;

            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : cur_row + 1'b1;
            end else begin
                col_d = cur_col + 1'b1;
                row_d = cur_row;
            end

            frame_done_d = last_row && last_col;

            // Windows whose left columns would come from the previous line are never flagged.
            win_valid_d = (cur_row >= ROW_W'(WIN - 1)) && (cur_col >= COL_W'(WIN - 1));
            if (win_valid_d) begin
                win_row_d = cur_row;
                win_col_d = cur_col;
            end

            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN - 1; c++) begin
                    win_d[r*WIN+c] = win_q[r*WIN+c+1];
                end
                win_d[r*WIN+WIN-1] = col_in[r];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q        <= '0;
            col_q        <= '0;
            ptr_q        <= '0;
            win_q        <= '{default: '0};
            win_valid_q  <= 1'b0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            row_q        <= row_d;
            col_q        <= col_d;
            ptr_q        <= ptr_d;
            win_q        <= win_d;
            win_valid_q  <= win_valid_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign xarray     = win_q;
    assign win_valid  = win_valid_q;
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_linebuffer_window9.sv
// Directed bench for linebuffer_window9: whole frames are streamed from a known pixel pattern
// and every accept is compared against a window model built from that pattern.
module tb_linebuffer_window9;
    import lr_pkg::*;

    localparam int W = 28;
    localparam int H = 28;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_sof;
    pix_t       in_data;
    pix_t       xarray [0:NFEAT-1];
    logic       win_valid;
    logic [4:0] win_row;
    logic [4:0] win_col;
    logic       frame_done;

    int total = 0;
    int bad   = 0;
    int pulses;
    int dones;
    bit last_ok;
    int last_r;
    int last_c;

    always #5 clk = ~clk;

    linebuffer_window9 #(.IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_data    (in_data),
        .xarray     (xarray),
        .win_valid  (win_valid),
        .win_row    (win_row),
        .win_col    (win_col),
        .frame_done (frame_done)
    );

    function automatic int pix(input int r, input int c, input int off);
        return (r * W + c + off) % 128;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Window whose newest pixel is (rr,cc): slot k holds pixel (rr-8+k/9, cc-8+k%9).
    task automatic check_win(input int rr, input int cc, input int off);
        for (int k = 0; k < NFEAT; k++) begin
            check($sformatf("xarray[%0d]@(%0d,%0d)", k, rr, cc), xarray[k],
                  pix(rr - 8 + k / 9, cc - 8 + k % 9, off));
        end
    endtask

    task automatic push(input bit v, input bit sof, input int d);
        in_valid = v;
        in_sof   = sof;
        in_data  = pix_t'(d);
        @(posedge clk);
        #1;
    endtask

    // Streams npix pixels of pattern 'off' starting at frame position (0,0).
    task automatic run_frame(input int off, input bit use_sof, input int idle_pct, input int npix);
        pulses  = 0;
        dones   = 0;
        last_ok = 1'b0;
        for (int i = 0; i < npix; i++) begin
            int r;
            int c;
            r = i / W;
            c = i % W;
            while (int'($urandom_range(99)) < idle_pct) begin
                push(1'b0, 1'b0, 0);
                check("gap_win_valid", win_valid, 0);
                check("gap_frame_done", frame_done, 0);
                if (last_ok) check_win(last_r, last_c, off);
            end
            push(1'b1, use_sof && (i == 0), pix(r, c, off));
            check($sformatf("win_valid@(%0d,%0d)", r, c), win_valid, (r >= 8 && c >= 8));
            check($sformatf("frame_done@(%0d,%0d)", r, c), frame_done, (r == H - 1 && c == W - 1));
            if (win_valid === 1'b1) pulses++;
            if (frame_done === 1'b1) dones++;
            last_ok = (r >= 8 && c >= 8);
            if (last_ok) begin
                last_r = r;
                last_c = c;
                check("win_row", win_row, r);
                check("win_col", win_col, c);
                check_win(r, c, off);
                if (pulses == 1) check("first_pulse_accept", i + 1, 233);
            end
        end
        if (npix == W * H) begin
            check("pulses_per_frame", pulses, 400);
            check("frame_done_pulses", dones, 1);
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_win_valid", win_valid, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_win_row", win_row, 0);
        check("rst_win_col", win_col, 0);
        check("rst_xarray0", xarray[0], 0);
        check("rst_xarray80", xarray[80], 0);
        rst = 1'b0;

        // Continuous frame with sof; explicit first-window values.
        run_frame(0, 1'b1, 0, 233);
        check("first_x0", xarray[0], 0);
        check("first_x8", xarray[8], 8);
        check("first_x72", xarray[72], 96);
        check("first_x80", xarray[80], 104);
        run_frame(0, 1'b1, 0, W * H);

        // Same frame with ~40% idle cycles.
        run_frame(0, 1'b1, 40, W * H);

        // Next frame without sof, different pattern so frame leakage would show.
        run_frame(50, 1'b0, 0, W * H);

        // Reset in the middle of a stream.
        run_frame(3, 1'b1, 0, 300);
        in_valid = 1'b0;
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_win_valid", win_valid, 0);
        check("midrst_frame_done", frame_done, 0);
        check("midrst_win_row", win_row, 0);
        check("midrst_win_col", win_col, 0);
        for (int k = 0; k < NFEAT; k++) check($sformatf("midrst_xarray[%0d]", k), xarray[k], 0);
        rst = 1'b0;
        run_frame(7, 1'b0, 0, W * H);

        // sof at (12,5) restarts the frame.
        run_frame(11, 1'b0, 0, 12 * W + 5);
        run_frame(20, 1'b1, 0, W * H);

        // sof on the last pixel slot: taken as (0,0), no frame_done, no window.
        run_frame(5, 1'b0, 0, W * H - 1);
        push(1'b1, 1'b1, 77);
        check("sof_last_frame_done", frame_done, 0);
        check("sof_last_win_valid", win_valid, 0);
        push(1'b0, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
